// File: rtl/rv_ifetch.sv
// Instruction fetch stage: four byte reads per instruction, little-endian assembly,
// valid/ready hand-off to decode, redirects from execute at any time.
module rv_ifetch #(
    parameter int                 ADDR_W   = 10,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        r_q, r_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        lane_q [0:2];
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic [31:0]       count_q, count_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              handshake;

    assign handshake = valid_q && instr_ready;

    // k_q is the index of the next byte read to issue; the first read of a new
    // instruction is issued straight from the handshake/redirect decision.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        k_d        = k_q;
        r_d        = r_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        count_d    = count_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        rd_pend_d  = mem_rd_q && !redirect_valid;

        if (rd_pend_q) begin
            r_d = r_q + 2'd1;
            if (r_q == 2'd3) begin
                instr_d    = {mem_rdata, lane_q[2], lane_q[1], lane_q[0]};
                instr_pc_d = pc_q;
                valid_d    = 1'b1;
                state_d    = HOLD;
            end
        end

        case (state_q)
            FETCH: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = pc_q + ADDR_W'(k_q);
                k_d        = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (handshake) begin
                    valid_d    = 1'b0;
                    pc_d       = pc_q + ADDR_W'(4);
                    state_d    = FETCH;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = pc_d;
                    k_d        = 2'd1;
                end
            end
            default: ;
        endcase

        if (handshake) begin
            count_d = count_q + 32'd1;
        end

        // Redirect overrides the sequential pc+4 and discards any partial fetch.
        if (redirect_valid) begin
            pc_d       = redirect_pc & ~ADDR_W'(3);
            k_d        = 2'd1;
            r_d        = 2'd0;
            valid_d    = 1'b0;
            state_d    = FETCH;
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            k_q        <= 2'd0;
            r_q        <= 2'd0;
            rd_pend_q  <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            k_q        <= k_d;
            r_q        <= r_d;
            rd_pend_q  <= rd_pend_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Lanes 0..2 are buffered; lane 3 goes straight from mem_rdata into instr.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rd_pend_q && r_q == 2'(gi)) begin
                    lane_q[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_rv_ifetch.sv
// Directed bench for rv_ifetch: reset, back-pressure, redirects, pc wrap, reset mid-drain.
module tb_rv_ifetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, instr_ready, redirect_valid;
    logic [9:0]  redirect_pc;
    logic        mem_rd, instr_valid;
    logic [9:0]  mem_addr, instr_pc;
    logic [7:0]  mem_rdata;
    logic [31:0] instr, fetch_count;

    logic        w_mem_rd, w_instr_valid;
    logic [9:0]  w_mem_addr, w_instr_pc;
    logic [7:0]  w_mem_rdata;
    logic [31:0] w_instr, w_fetch_count;
    logic        w_ready, w_redirect;
    logic [9:0]  w_redirect_pc;

    logic [7:0] mem  [0:1023];
    logic [7:0] wmem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    rv_ifetch #(.ADDR_W(10), .RESET_PC(10'h000)) u_dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    rv_ifetch #(.ADDR_W(10), .RESET_PC(10'h3FC)) u_wrap (
        .clk(clk), .reset(reset), .mem_rd(w_mem_rd), .mem_addr(w_mem_addr),
        .mem_rdata(w_mem_rdata), .instr(w_instr), .instr_pc(w_instr_pc),
        .instr_valid(w_instr_valid), .instr_ready(w_ready),
        .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
        .fetch_count(w_fetch_count)
    );

    always @(posedge clk) begin
        if (mem_rd)   mem_rdata   <= mem[mem_addr];
        if (w_mem_rd) w_mem_rdata <= wmem[w_mem_addr];
    end

    always @(posedge clk) begin
        if (!reset && instr_valid && instr_ready)
            $display("xfer main pc=%h instr=%h count=%0d", instr_pc, instr, fetch_count);
        if (!reset && w_instr_valid && w_ready)
            $display("xfer wrap pc=%h instr=%h count=%0d", w_instr_pc, w_instr, w_fetch_count);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [9:0] a);
        check({tag, ".rd"}, 32'(mem_rd), 32'd1);
        check({tag, ".addr"}, 32'(mem_addr), 32'(a));
    endtask

    task automatic nord(input string tag);
        check({tag, ".nord"}, 32'(mem_rd), 32'd0);
    endtask

    task automatic wrd(input string tag, input logic [9:0] a);
        check({tag, ".wrd"}, 32'(w_mem_rd), 32'd1);
        check({tag, ".waddr"}, 32'(w_mem_addr), 32'(a));
    endtask

    task automatic out(input string tag, input logic [31:0] i, input logic [9:0] pc, input logic [31:0] fc);
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".instr"}, instr, i);
        check({tag, ".pc"}, 32'(instr_pc), 32'(pc));
        check({tag, ".count"}, fetch_count, fc);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 8'hFF;
            wmem[i] = 8'hFF;
        end
        {mem[3], mem[2], mem[1], mem[0]}                 = 32'h00100513;
        {mem[7], mem[6], mem[5], mem[4]}                 = 32'h00200593;
        {mem[11], mem[10], mem[9], mem[8]}               = 32'h00300613;
        {mem[35], mem[34], mem[33], mem[32]}             = 32'h04030201;
        {mem[67], mem[66], mem[65], mem[64]}             = 32'h12345678;
        mem[68] = 8'hAA;
        mem[69] = 8'hBB;
        {mem[259], mem[258], mem[257], mem[256]}         = 32'hDEADBEEF;
        {wmem[1023], wmem[1022], wmem[1021], wmem[1020]} = 32'h04030201;
        {wmem[3], wmem[2], wmem[1], wmem[0]}             = 32'h44332211;

        reset = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        w_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0;
        repeat (2) @(posedge clk);
        tick();
        check("rst.rd", 32'(mem_rd), 32'd0);
        check("rst.addr", 32'(mem_addr), 32'd0);
        check("rst.instr", instr, 32'd0);
        check("rst.pc", 32'(instr_pc), 32'd0);
        check("rst.valid", 32'(instr_valid), 32'd0);
        check("rst.count", fetch_count, 32'd0);
        reset = 1'b0;

        // First fetch after reset; wrap instance fetches from 0x3FC in lockstep.
        tick(); rd("f1.0", 10'h000); wrd("w1.0", 10'h3FC);
        tick(); rd("f1.1", 10'h001); wrd("w1.1", 10'h3FD);
        tick(); rd("f1.2", 10'h002); wrd("w1.2", 10'h3FE);
        tick(); rd("f1.3", 10'h003); wrd("w1.3", 10'h3FF);
        tick(); nord("f1.drain"); check("f1.novalid", 32'(instr_valid), 32'd0);
        tick(); out("f1.out", 32'h00100513, 10'h000, 32'd0);
        check("w1.instr", w_instr, 32'h04030201);
        check("w1.pc", 32'(w_instr_pc), 32'h3FC);
        tick(); check("f2.count", fetch_count, 32'd1); check("f2.valid", 32'(instr_valid), 32'd0);
        rd("f2.0", 10'h004); wrd("w2.0", 10'h000);
        tick(); rd("f2.1", 10'h005); wrd("w2.1", 10'h001);
        tick(); rd("f2.2", 10'h006); wrd("w2.2", 10'h002);
        tick(); rd("f2.3", 10'h007); wrd("w2.3", 10'h003);
        instr_ready = 1'b0;
        tick(); nord("f2.drain");
        tick(); out("f2.out", 32'h00200593, 10'h004, 32'd1);
        check("w2.instr", w_instr, 32'h44332211);
        check("w2.pc", 32'(w_instr_pc), 32'h000);

        // Back-pressure: output frozen, no reads, address held.
        for (int i = 0; i < 10; i++) begin
            out("stall", 32'h00200593, 10'h004, 32'd1);
            nord("stall");
            check("stall.addr", 32'(mem_addr), 32'h007);
            if (i < 9) tick();
        end
        instr_ready = 1'b1;
        tick(); check("f3.count", fetch_count, 32'd2); check("f3.valid", 32'(instr_valid), 32'd0);
        rd("f3.0", 10'h008);
        tick(); rd("f3.1", 10'h009);
        tick(); rd("f3.2", 10'h00A);
        tick(); rd("f3.3", 10'h00B);
        tick(); nord("f3.drain");
        tick(); out("f3.out", 32'h00300613, 10'h008, 32'd2);

        // Redirect together with handshake.
        redirect_valid = 1'b1; redirect_pc = 10'h040;
        tick(); redirect_valid = 1'b0;
        check("hsr.count", fetch_count, 32'd3); check("hsr.valid", 32'(instr_valid), 32'd0);
        rd("hsr.0", 10'h040);
        tick(); rd("hsr.1", 10'h041);
        tick(); rd("hsr.2", 10'h042);
        tick(); rd("hsr.3", 10'h043);
        tick(); nord("hsr.drain");
        tick(); out("hsr.out", 32'h12345678, 10'h040, 32'd3);

        // Redirect mid-fetch after two reads, unaligned target.
        tick(); check("mf.count", fetch_count, 32'd4); rd("mf.0", 10'h044);
        tick(); rd("mf.1", 10'h045);
        redirect_valid = 1'b1; redirect_pc = 10'h102;
        tick(); redirect_valid = 1'b0;
        rd("rd.0", 10'h100); check("rd.valid", 32'(instr_valid), 32'd0);
        tick(); rd("rd.1", 10'h101);
        tick(); rd("rd.2", 10'h102);
        tick(); rd("rd.3", 10'h103);
        tick(); nord("rd.drain");
        tick(); out("rd.out", 32'hDEADBEEF, 10'h100, 32'd4);

        // Redirect to 0x20, then reset while its bytes are in flight.
        tick(); check("r20.count", fetch_count, 32'd5); rd("r20.pre", 10'h104);
        redirect_valid = 1'b1; redirect_pc = 10'h020;
        tick(); redirect_valid = 1'b0; rd("r20.0", 10'h020);
        tick(); rd("r20.1", 10'h021);
        tick(); rd("r20.2", 10'h022);
        tick(); rd("r20.3", 10'h023);
        tick(); nord("r20.drain"); check("r20.novalid", 32'(instr_valid), 32'd0);
        reset = 1'b1;
        tick(); reset = 1'b0;
        check("mrst.valid", 32'(instr_valid), 32'd0);
        check("mrst.count", fetch_count, 32'd0);
        check("mrst.instr", instr, 32'd0);
        nord("mrst");
        check("mrst.addr", 32'(mem_addr), 32'd0);
        tick(); rd("rf.0", 10'h000); check("rf.novalid0", 32'(instr_valid), 32'd0);
        tick(); rd("rf.1", 10'h001); check("rf.novalid1", 32'(instr_valid), 32'd0);
        tick(); rd("rf.2", 10'h002);
        tick(); rd("rf.3", 10'h003);
        tick(); nord("rf.drain"); check("rf.novalid4", 32'(instr_valid), 32'd0);
        tick(); out("rf.out", 32'h00100513, 10'h000, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
